// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed 7-segment scanner with per-frame snapshot and alarm blink
module clock_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 40,
  parameter bit          LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  input  logic [3:0] S_out1,
  input  logic [3:0] S_out0,
  input  logic       Alarm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int unsigned    PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0]     FRAME_MAX = 8'(BLINK_FRAMES - 1);
  localparam logic [2:0]     LAST_DIG  = 3'd5;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    digit_q, digit_d;
  logic [1:0]    snap_h1_q, snap_h1_d;
  logic [3:0]    snap_h0_q, snap_h0_d;
  logic [3:0]    snap_m1_q, snap_m1_d;
  logic [3:0]    snap_m0_q, snap_m0_d;
  logic [3:0]    snap_s1_q, snap_s1_d;
  logic [3:0]    snap_s0_q, snap_s0_d;
  logic          snap_alarm_q, snap_alarm_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;

  logic          scan_tick;
  logic          frame_start;
  logic [3:0]    digit_val;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    // {g,f,e,d,c,b,a}, active-low
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign scan_tick   = (presc_q == PRESC_MAX);
  assign frame_start = scan_tick && (digit_q == LAST_DIG);

  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (scan_tick) begin
      presc_d = '0;
      digit_d = (digit_q == LAST_DIG) ? 3'd0 : digit_q + 3'd1;
    end
  end

  always_comb begin
    snap_h1_d    = snap_h1_q;
    snap_h0_d    = snap_h0_q;
    snap_m1_d    = snap_m1_q;
    snap_m0_d    = snap_m0_q;
    snap_s1_d    = snap_s1_q;
    snap_s0_d    = snap_s0_q;
    snap_alarm_d = snap_alarm_q;
    frame_cnt_d  = frame_cnt_q;
    phase_d      = phase_q;
    if (frame_start) begin
      snap_h1_d    = H_out1;
      snap_h0_d    = H_out0;
      snap_m1_d    = M_out1;
      snap_m0_d    = M_out0;
      snap_s1_d    = S_out1;
      snap_s0_d    = S_out0;
      snap_alarm_d = Alarm;
      // Counting starts only once the previous frame already carried the alarm,
      // so the first alarmed frame is visible and a dropped alarm unblanks at once.
      if (Alarm && snap_alarm_q) begin
        if (frame_cnt_q == FRAME_MAX) begin
          frame_cnt_d = 8'd0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end else begin
        frame_cnt_d = 8'd0;
        phase_d     = 1'b0;
      end
    end
  end

  always_comb begin
    case (digit_q)
      3'd0:    digit_val = snap_s0_q;
      3'd1:    digit_val = snap_s1_q;
      3'd2:    digit_val = snap_m0_q;
      3'd3:    digit_val = snap_m1_q;
      3'd4:    digit_val = snap_h0_q;
      3'd5:    digit_val = {2'b00, snap_h1_q};
      default: digit_val = 4'd0;
    endcase
  end

  always_comb begin
    blank = phase_q || (LZB && (digit_q == LAST_DIG) && (snap_h1_q == 2'd0));
    an_d  = ~(6'b000001 << digit_q);
    seg_d = seg_decode(digit_val);
    dp_d  = !((digit_q == 3'd2) || (digit_q == 3'd4));
    if (blank) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      digit_q      <= 3'd0;
      snap_h1_q    <= 2'd0;
      snap_h0_q    <= 4'd0;
      snap_m1_q    <= 4'd0;
      snap_m0_q    <= 4'd0;
      snap_s1_q    <= 4'd0;
      snap_s0_q    <= 4'd0;
      snap_alarm_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      phase_q      <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= 6'h3F;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      snap_h1_q    <= snap_h1_d;
      snap_h0_q    <= snap_h0_d;
      snap_m1_q    <= snap_m1_d;
      snap_m0_q    <= snap_m0_d;
      snap_s1_q    <= snap_s1_d;
      snap_s0_q    <= snap_s0_d;
      snap_alarm_q <= snap_alarm_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan (SCAN_DIV=4, BLINK_FRAMES=2)
module tb_clock_display_scan;

  localparam int FRAME = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] h_out1 = '0;
  logic [3:0] h_out0 = '0, m_out1 = '0, m_out0 = '0, s_out1 = '0, s_out0 = '0;
  logic       alarm = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n;

  clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZB(1'b1)) dut (
    .clk(clk), .reset(reset),
    .H_out1(h_out1), .H_out0(h_out0), .M_out1(m_out1), .M_out0(m_out0),
    .S_out1(s_out1), .S_out0(s_out0), .Alarm(alarm),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // edges since reset release; output for frame m digit d follows edges 24m+1+4d .. 24m+4+4d
  always @(posedge clk or negedge reset)
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  function automatic logic [6:0] pattern(input logic [3:0] v);
    case (v)
      4'd0: pattern = 7'h40;
      4'd1: pattern = 7'h79;
      4'd2: pattern = 7'h24;
      4'd3: pattern = 7'h30;
      4'd4: pattern = 7'h19;
      4'd5: pattern = 7'h12;
      4'd6: pattern = 7'h02;
      4'd7: pattern = 7'h78;
      4'd8: pattern = 7'h00;
      4'd9: pattern = 7'h10;
      default: pattern = 7'h3F;
    endcase
  endfunction

  task automatic set_time(input int h1, input int h0, input int m1, input int m0,
                          input int s1, input int s0);
    h_out1 = 2'(h1); h_out0 = 4'(h0); m_out1 = 4'(m1);
    m_out0 = 4'(m0); s_out1 = 4'(s1); s_out0 = 4'(s0);
  endtask

  task automatic push_frame(input int h1, input int h0, input int m1, input int m0,
                            input int s1, input int s0, input bit blank_all);
    logic [3:0] vals [6];
    exp_t e;
    vals[0] = 4'(s0); vals[1] = 4'(s1); vals[2] = 4'(m0);
    vals[3] = 4'(m1); vals[4] = 4'(h0); vals[5] = 4'(h1);
    for (int d = 0; d < 6; d++) begin
      e.an  = 6'h3F;
      e.an[d] = 1'b0;
      e.seg = pattern(vals[d]);
      e.dp  = (d == 2 || d == 4) ? 1'b0 : 1'b1;
      if (blank_all || (d == 5 && vals[5] == 4'd0)) begin
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic goto_edge(input int k);
    int guard = 0;
    while (edge_n < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != k) begin
      checks++; errors++;
      $display("FAIL goto_edge: at edge %0d, required edge %0d", edge_n, k);
    end
  endtask

  task automatic check_frame(input int m, input string name);
    exp_t e;
    for (int d = 0; d < 6; d++) begin
      goto_edge(FRAME * m + 2 + 4 * d);
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard empty: frame %0d digit %0d", name, m, d);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (an !== e.an) begin
          errors++;
          $display("FAIL %s an frame %0d digit %0d: got %b, expected %b", name, m, d, an, e.an);
        end
        checks++;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL %s seg frame %0d digit %0d: got %b, expected %b", name, m, d, seg, e.seg);
        end
        checks++;
        if (dp !== e.dp) begin
          errors++;
          $display("FAIL %s dp frame %0d digit %0d: got %b, expected %b", name, m, d, dp, e.dp);
        end
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (an !== 6'h3F) begin errors++; $display("FAIL %s an: got %b, expected 111111", name, an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL %s seg: got %b, expected 1111111", name, seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL %s dp: got %b, expected 1", name, dp); end
  endtask

  task automatic check_first_edge(input string name);
    goto_edge(1);
    checks++;
    if (an !== 6'b111110) begin errors++; $display("FAIL %s an: got %b, expected 111110", name, an); end
    checks++;
    if (seg !== 7'h40) begin errors++; $display("FAIL %s seg: got %b, expected 1000000", name, seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL %s dp: got %b, expected 1", name, dp); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    reset = 1'b1;
    check_first_edge("reset_release");
    // new inputs must not reach the display before the first frame start
    set_time(1, 0, 1, 9, 0, 0);
    push_frame(0, 0, 0, 0, 0, 0, 1'b0);
    check_frame(0, "zero_snapshot");
  endtask

  task automatic test_steady;
    push_frame(1, 0, 1, 9, 0, 0, 1'b0);
    check_frame(1, "steady_1019");
  endtask

  task automatic test_midframe;
    push_frame(1, 0, 1, 9, 0, 0, 1'b0);
    push_frame(1, 0, 2, 0, 0, 0, 1'b0);
    goto_edge(FRAME * 2 + 2);
    set_time(1, 0, 2, 0, 0, 0);
    check_frame(2, "midframe_old");
    check_frame(3, "midframe_new");
  endtask

  task automatic test_lzb_dash;
    set_time(0, 9, 4, 12, 5, 15);
    push_frame(0, 9, 4, 12, 5, 15, 1'b0);
    check_frame(4, "lzb_dash");
  endtask

  task automatic test_alarm_blink;
    set_time(1, 2, 3, 4, 5, 6);
    alarm = 1'b1;
    for (int m = 5; m <= 10; m++) begin
      push_frame(1, 2, 3, 4, 5, 6, (m == 7 || m == 8));
      check_frame(m, "alarm_blink");
    end
    push_frame(1, 2, 3, 4, 5, 6, 1'b1);
    goto_edge(FRAME * 11 + 1);
    alarm = 1'b0;
    check_frame(11, "alarm_drop_blank");
    push_frame(1, 2, 3, 4, 5, 6, 1'b0);
    check_frame(12, "alarm_resume");
    push_frame(1, 2, 3, 4, 5, 6, 1'b0);
    check_frame(13, "alarm_steady");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_first_edge("async_release");
    push_frame(0, 0, 0, 0, 0, 0, 1'b0);
    check_frame(0, "async_zero_snapshot");
  endtask

  initial begin
    test_reset;
    test_steady;
    test_midframe;
    test_lzb_dash;
    test_alarm_blink;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each digit stays enabled; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 40: full scan frames per blink half-period; legal range 1..255.
REQ-003 Parameter LZB, default 1: 1 blanks H_out1 digit when its value is 0.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 H_out1  input  2  hours tens BCD from the alarm clock core.
REQ-007 H_out0, M_out1, M_out0, S_out1, S_out0  input  4 each  hours units, minutes tens/units, seconds tens/units BCD.
REQ-008 Alarm  input  1  alarm-active flag from the core.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 an  output  6  digit enables, active-low, one-hot-low; an[0] = rightmost digit.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1 and wraps; scan tick = cycle where prescaler equals SCAN_DIV-1.
REQ-013 Digit index 0..5 advances by 1 on each scan tick; wraps 5 -> 0.
REQ-014 Digit map: 0=S_out0, 1=S_out1, 2=M_out0, 3=M_out1, 4=H_out0, 5=H_out1 (zero-extended to 4 bits).
REQ-015 Frame start = scan tick with digit index 5; on that edge all six time inputs and Alarm are captured into a snapshot register.
REQ-016 Displayed digits always come from the snapshot, never directly from inputs (no tearing within a frame).
REQ-017 seg, dp, an are registered; they reflect the current digit index and snapshot with exactly one clk of latency.
REQ-018 Decoder: 0-9 standard 7-segment patterns (0 = all on except g; 1 = b,c; 8 = all on); values 10-15 display "-" (only g lit).
REQ-019 dp lit (0) only on digits 2 and 4 (hh.mm.ss separators); otherwise 1.
REQ-020 an has exactly one bit low at any time outside reset; bit low = digit index.
REQ-021 LZB=1 and snapshot H_out1 = 0: while digit 5 is selected, seg = 7'h7F and dp = 1; an[5] still driven low.
REQ-022 Blink state: frame counter 0..BLINK_FRAMES-1 and phase bit; counter increments at each frame start, on wrap phase toggles.
REQ-023 When snapshot Alarm = 0: frame counter and phase held at 0.
REQ-024 Snapshot Alarm 0 -> 1: first BLINK_FRAMES frames displayed (phase 0), next BLINK_FRAMES blanked (phase 1), repeating.
REQ-025 Phase 1: seg = 7'h7F, dp = 1 for all digits; an scanning continues unchanged.
REQ-026 Alarm falling mid-blank: display resumes at the next frame start (snapshot update), not earlier.
REQ-027 Input changes between frame starts are ignored until the next frame start.

Reset
REQ-028 While reset = 0: prescaler, digit index, frame counter, phase and snapshot = 0; an = 6'h3F, seg = 7'h7F, dp = 1.
REQ-029 Reset asserted mid-frame forces REQ-028 values immediately, without waiting for a clock edge.
REQ-030 First rising edge after reset deassertion: an = 6'b111110, seg = pattern "0", dp = 1.

Verification (bench uses SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset, inputs 10:19:00 held -> after first frame start, the next frame shows an sequence 111110..011111 every 4 clks, seg digits 0,0,9,1,0,1; dp low on digits 2 and 4.
REQ-032 Inputs change 10:19 -> 10:20 mid-frame -> current frame still shows 19; next frame shows 20.
REQ-033 H_out1=0, H_out0=9, LZB=1 -> digit 5 seg = 7'h7F; digit 4 shows 9 with dp low.
REQ-034 M_out0 = 4'hC -> digit 2 seg = only g lit (7'b0111111).
REQ-035 Alarm=1 held -> 2 frames visible, 2 frames all seg 7'h7F, repeating; Alarm=0 -> display steady from next frame start.
REQ-036 Reset pulsed low mid-scan -> an = 6'h3F and seg = 7'h7F with no clock edge; after release, REQ-030 holds.
